// File: rtl/alert_beeper.sv
// alert_beeper: plays beepCount short or long beeps separated by silences, timed by a DIV-cycle tick.
module alert_beeper #(
    parameter int DIV        = 50000,
    parameter int ON_TICKS   = 200,
    parameter int LONG_TICKS = 600,
    parameter int OFF_TICKS  = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] beepCount,
    input  logic       longBeep,
    input  logic       abort,
    output logic       beeLED,
    output logic       busy,
    output logic       done
);
    localparam int PW   = $clog2(DIV);
    localparam int TMAX = (ON_TICKS > LONG_TICKS ? (ON_TICKS > OFF_TICKS ? ON_TICKS : OFF_TICKS)
                                                 : (LONG_TICKS > OFF_TICKS ? LONG_TICKS : OFF_TICKS));
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [PW-1:0] PRE_L  = PW'(DIV - 1);
    localparam logic [TW-1:0] ON_L   = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] LONG_L = TW'(LONG_TICKS - 1);
    localparam logic [TW-1:0] OFF_L  = TW'(OFF_TICKS - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          long_q, long_d, led_q, led_d, busy_q, busy_d, done_q, done_d;
    logic          tick, phase_end;
    logic [TW-1:0] last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            tick_q  <= '0;
            cnt_q   <= '0;
            long_q  <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            long_q  <= long_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A phase ends on the prescaler wrap that completes its last tick.
    always_comb begin
        tick      = (state_q != IDLE) && (pre_q == PRE_L);
        last      = (state_q == ON) ? (long_q ? LONG_L : ON_L) : OFF_L;
        phase_end = tick && (tick_q == last);
        state_d   = state_q;
        pre_d     = pre_q;
        tick_d    = tick_q;
        cnt_d     = cnt_q;
        long_d    = long_q;
        led_d     = led_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (abort) begin
            state_d = IDLE;
            pre_d   = '0;
            tick_d  = '0;
            cnt_d   = '0;
            long_d  = 1'b0;
            led_d   = 1'b0;
            busy_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (start && beepCount != 3'd0) begin
                state_d = ON;
                pre_d   = '0;
                tick_d  = '0;
                cnt_d   = beepCount;
                long_d  = longBeep;
                led_d   = 1'b1;
                busy_d  = 1'b1;
            end else begin
                done_d  = start;
            end
        end else begin
            pre_d  = tick ? '0 : pre_q + 1'b1;
            tick_d = tick ? tick_q + 1'b1 : tick_q;
            if (phase_end) begin
                tick_d = '0;
                if (state_q == ON) begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == 3'd1) ? IDLE : OFF;
                    led_d   = 1'b0;
                    busy_d  = (cnt_q != 3'd1);
                    done_d  = (cnt_q == 3'd1);
                end else begin
                    state_d = ON;
                    led_d   = 1'b1;
                end
            end
        end
    end

    assign beeLED = led_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_alert_beeper.sv
// tb_alert_beeper: randomized and directed checks of alert_beeper against a cycle-budget reference model.
module tb_alert_beeper;
    localparam int DIV = 4, ON_T = 3, LONG_T = 5, OFF_T = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] beepCount = 3'd0;
    logic       longBeep = 1'b0;
    logic       abort = 1'b0;
    logic       beeLED, busy, done;
    int         checks = 0;
    int         errors = 0;

    bit m_led, m_busy, m_done, m_long;
    int m_left, m_beeps;

    alert_beeper #(.DIV(DIV), .ON_TICKS(ON_T), .LONG_TICKS(LONG_T), .OFF_TICKS(OFF_T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .beepCount(beepCount),
        .longBeep(longBeep), .abort(abort), .beeLED(beeLED), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model tracks the cycles left in the current phase and the beeps still to play.
    task automatic advance();
        @(posedge clk);
        if (!rst_n || abort) begin
            {m_led, m_busy, m_done, m_long} = '0;
            m_left = 0;
            m_beeps = 0;
        end else if (!m_busy) begin
            m_done = start && beepCount == 3'd0;
            if (start && beepCount != 3'd0) begin
                m_busy  = 1;
                m_led   = 1;
                m_long  = longBeep;
                m_beeps = beepCount;
                m_left  = (longBeep ? LONG_T : ON_T) * DIV;
            end
        end else begin
            m_done = 0;
            m_left--;
            if (m_left == 0) begin
                if (m_led) begin
                    m_beeps--;
                    m_led = 0;
                    if (m_beeps == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end else m_left = OFF_T * DIV;
                end else begin
                    m_led  = 1;
                    m_left = (m_long ? LONG_T : ON_T) * DIV;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        if ({beeLED, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset: got %b%b%b want 000", beeLED, busy, done);
        end
        checks++;
        advance();
        advance();
        rst_n = 1'b1;
        advance();
        if ({beeLED, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: got %b%b%b want 000", beeLED, busy, done);
        end
        checks++;
    endtask

    task automatic test_two_short();
        int led_n = 0, busy_n = 0, done_n = 0;
        start = 1; beepCount = 3'd2; longBeep = 0;
        advance();
        start = 0;
        for (int i = 0; i < 40; i++) begin
            led_n += beeLED; busy_n += busy; done_n += done;
            if ({beeLED, busy, done} !== {m_led, m_busy, m_done}) begin
                errors++;
                $display("FAIL two_short c%0d: got %b%b%b want %b%b%b", i, beeLED, busy, done, m_led, m_busy, m_done);
            end
            checks++;
            if (done && beeLED !== 1'b0) begin
                errors++;
                $display("FAIL two_short_done_led: led %b want 0", beeLED);
            end
            advance();
        end
        if (led_n != 2 * ON_T * DIV || busy_n != (2 * ON_T + OFF_T) * DIV || done_n != 1) begin
            errors++;
            $display("FAIL two_short_totals: led %0d busy %0d done %0d want %0d %0d 1",
                     led_n, busy_n, done_n, 2 * ON_T * DIV, (2 * ON_T + OFF_T) * DIV);
        end
        checks++;
    endtask

    task automatic test_long_change();
        int led_n = 0, done_n = 0;
        start = 1; beepCount = 3'd1; longBeep = 1;
        advance();
        start = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) begin beepCount = 3'd5; longBeep = 0; end
            led_n += beeLED; done_n += done;
            if ({beeLED, busy, done} !== {m_led, m_busy, m_done}) begin
                errors++;
                $display("FAIL long_change c%0d: got %b%b%b want %b%b%b", i, beeLED, busy, done, m_led, m_busy, m_done);
            end
            checks++;
            advance();
        end
        if (led_n != LONG_T * DIV || done_n != 1) begin
            errors++;
            $display("FAIL long_totals: led %0d done %0d want %0d 1", led_n, done_n, LONG_T * DIV);
        end
        checks++;
    endtask

    task automatic test_zero();
        start = 1; beepCount = 3'd0; longBeep = 0;
        advance();
        start = 0;
        if ({beeLED, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL zero_done: got %b%b%b want 001", beeLED, busy, done);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            advance();
            if ({beeLED, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL zero_after c%0d: got %b%b%b want 000", i, beeLED, busy, done);
            end
            checks++;
        end
    endtask

    task automatic test_abort();
        start = 1; beepCount = 3'd3; longBeep = 0;
        advance();
        start = 0;
        repeat (14) advance();
        abort = 1;
        advance();
        abort = 0;
        if ({beeLED, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_off: got %b%b%b want 000", beeLED, busy, done);
        end
        checks++;
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done c%0d: done %b want 0", i, done);
            end
            checks++;
            advance();
        end
        start = 1; beepCount = 3'd3;
        advance();
        start = 0;
        for (int i = 0; i < 60; i++) begin
            if ({beeLED, busy, done} !== {m_led, m_busy, m_done}) begin
                errors++;
                $display("FAIL abort_restart c%0d: got %b%b%b want %b%b%b", i, beeLED, busy, done, m_led, m_busy, m_done);
            end
            checks++;
            advance();
        end
    endtask

    task automatic test_back_to_back();
        start = 1; beepCount = 3'd2; longBeep = 0;
        for (int i = 0; i < 45; i++) begin
            advance();
            beepCount = 3'($urandom_range(0, 7));
            longBeep = 1'($urandom_range(0, 1));
            start = (i < 30);
            if ({beeLED, busy, done} !== {m_led, m_busy, m_done}) begin
                errors++;
                $display("FAIL back_to_back c%0d: got %b%b%b want %b%b%b", i, beeLED, busy, done, m_led, m_busy, m_done);
            end
            checks++;
        end
        start = 0;
        repeat (30) advance();
        start = 1; abort = 1; beepCount = 3'd4;
        advance();
        start = 0; abort = 0;
        for (int i = 0; i < 5; i++) begin
            if ({beeLED, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL start_abort c%0d: got %b%b%b want 000", i, beeLED, busy, done);
            end
            checks++;
            advance();
        end
    endtask

    task automatic test_async_reset();
        start = 1; beepCount = 3'd2; longBeep = 0;
        advance();
        start = 0;
        repeat (5) advance();
        #3 rst_n = 1'b0;
        #1;
        if ({beeLED, busy} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got led %b busy %b want 00", beeLED, busy);
        end
        checks++;
        advance();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            advance();
            if ({beeLED, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL async_after c%0d: got %b%b%b want 000", i, beeLED, busy, done);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 60) == 0);
            beepCount = 3'($urandom_range(0, 7));
            longBeep = 1'($urandom_range(0, 1));
            advance();
            if ({beeLED, busy, done} !== {m_led, m_busy, m_done}) begin
                errors++;
                $display("FAIL random c%0d: got %b%b%b want %b%b%b", i, beeLED, busy, done, m_led, m_busy, m_done);
            end
            checks++;
        end
        start = 0; abort = 0;
    endtask

    initial begin
        test_reset();
        test_two_short();
        test_long_change();
        test_zero();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alert_beeper.md
ALERT_BEEPER -- requirements
Module: alert_beeper

Interface
REQ-001 Parameter DIV, default 50000: clk cycles per time tick; SHALL be >= 2.
REQ-002 Parameter ON_TICKS, default 200: ticks per short beep; SHALL be >= 1.
REQ-003 Parameter LONG_TICKS, default 600: ticks per long beep; SHALL be >= 1.
REQ-004 Parameter OFF_TICKS, default 200: ticks of silence between beeps; SHALL be >= 1.
REQ-005 clk  in  1  single system clock; all state SHALL change on its rising edge only.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  one-cycle request pulse, already synchronized by the input stage.
REQ-008 beepCount  in  3  number of beeps; sampled only with an accepted start.
REQ-009 longBeep  in  1  1 = each beep lasts LONG_TICKS; sampled only with an accepted start.
REQ-010 abort  in  1  level; silences and stops the pattern.
REQ-011 beeLED  out  1  beeper/LED drive, 1 = sounding.
REQ-012 busy  out  1  1 while a pattern is in progress.
REQ-013 done  out  1  one-cycle pulse when a pattern completes normally.

Function
REQ-014 States SHALL be IDLE, ON, OFF; all outputs registered.
REQ-015 start SHALL be accepted only in IDLE with abort=0; otherwise ignored, no queuing.
REQ-016 On an accepted start with beepCount!=0: next cycle state ON, beeLED=1, busy=1; beepCount and longBeep latched; prescaler and tick counter cleared.
REQ-017 On an accepted start with beepCount=0: next cycle done=1 for one cycle; state stays IDLE, busy and beeLED stay 0.
REQ-018 Prescaler SHALL count 0..DIV-1 only in ON or OFF, wrap to 0, and emit a tick in the cycle it equals DIV-1.
REQ-019 Tick counter SHALL clear on every state entry; a phase ends in the cycle its final tick occurs.
REQ-020 ON SHALL last exactly ON_TICKS*DIV cycles (LONG_TICKS*DIV if latched longBeep=1); the latched remaining count then decrements.
REQ-021 ON end with remaining count becoming 0: next cycle IDLE, beeLED=0, busy=0, done=1 for exactly that cycle.
REQ-022 ON end with remaining count nonzero: next cycle OFF, beeLED=0, busy=1.
REQ-023 OFF SHALL last exactly OFF_TICKS*DIV cycles, then next cycle ON, beeLED=1.
REQ-024 abort=1 in any state: next cycle IDLE, beeLED=0, busy=0, done=0, counters cleared; abort beats start in the same cycle.
REQ-025 Changes of beepCount/longBeep while busy SHALL not affect the running pattern.
REQ-026 Counter widths SHALL be sized from the parameters; no counter may overflow or wrap except as stated in REQ-018.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, beeLED=0, busy=0, done=0, all counters and latches 0, independent of clk.
REQ-028 After rst_n rises, the first accepted start SHALL behave exactly as REQ-016/017; a reset mid-pattern SHALL leave no residual done pulse.

Verification (DIV=4, ON_TICKS=3, LONG_TICKS=5, OFF_TICKS=2: short on 12, long on 20, off 8 cycles)
REQ-029 start, beepCount=2, longBeep=0 -> beeLED high 12, low 8, high 12 cycles; busy high 32 cycles; done single pulse in the cycle beeLED falls the second time.
REQ-030 start, beepCount=1, longBeep=1, then beepCount changes to 5 mid-beep -> exactly one 20-cycle beep, then done.
REQ-031 start, beepCount=0 -> done one cycle later for one cycle; beeLED and busy never assert.
REQ-032 start, beepCount=3; abort at cycle 15 (inside OFF) -> next cycle busy=0, beeLED=0; no done; a second start then plays a full pattern.
REQ-033 start repeated every cycle while busy, plus start and abort together in IDLE -> repeats ignored, pattern timing unchanged; simultaneous pair produces no activity.
REQ-034 rst_n low asynchronously mid-ON (between clk edges) -> beeLED and busy drop before the next clk edge; no done after release.
